ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- Single-slave AHB-to-APB bridge downstream of the AHB LED control unit.
- Converts each AHB transfer the control unit issues into one APB SETUP/ACCESS pair toward the GPIO register file.
- Returns HREADY/HRESP/HRDATA, which pace the control unit's FSM.
- The upstream master is non-pipelined: it presents HADDR, HWRITE and HWDATA together and holds them until it sees HREADY=1. The bridge samples all three in the same cycle.

Parameters:
- APB_BASE, 32'h0000_0000, decode base of the APB slave region.
- APB_MASK, 32'hFFFF_F000, decode mask. A transfer hits the slave when (iHADDR & APB_MASK) == APB_BASE.
- TIMEOUT, 16, maximum ACCESS cycles to wait for iPREADY before aborting with ERROR (legal range 1..65535).

Ports:
- iHCLK  in  1  bus clock
- iHRESETn  in  1  asynchronous active-low reset
- iHTRANS  in  2  AHB transfer type; a transfer is requested when bit[1]=1 (NONSEQ/SEQ)
- iHWRITE  in  1  1=write, 0=read
- iHADDR  in  32  transfer address
- iHWDATA  in  32  write data, valid together with the address
- oHREADY  out  1  transfer complete strobe (registered)
- oHRESP  out  2  00=OKAY, 01=ERROR (registered)
- oHRDATA  out  32  captured read data (registered)
- oPADDR  out  32  APB address
- oPSEL  out  1  APB select
- oPENABLE  out  1  APB enable
- oPWRITE  out  1  APB direction
- oPWDATA  out  32  APB write data
- iPRDATA  in  32  APB read data
- iPREADY  in  1  APB slave ready
- iPSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, iHRESETn=0):
  - state=IDLE; oHREADY=0, oHRESP=00, oHRDATA=0.
  - oPSEL=0, oPENABLE=0, oPWRITE=0, oPADDR=0, oPWDATA=0; timeout counter=0.
  - A reset mid-transfer drops oPSEL/oPENABLE immediately and asynchronously; no response is issued for the aborted transfer.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, OKAY_RSP, ERR1, ERR2.
- IDLE:
  - oHREADY=0, oHRESP=00.
  - If iHTRANS[1]=1 and the address decodes: latch iHADDR→oPADDR, iHWRITE→oPWRITE, iHWDATA→oPWDATA. Next: SETUP.
  - If iHTRANS[1]=1 and the address misses: next ERR1. No APB activity.
  - Otherwise stay in IDLE.
- SETUP: oPSEL=1, oPENABLE=0; clear the timeout counter. Next: ACCESS.
- ACCESS:
  - oPSEL=1, oPENABLE=1; the counter increments each cycle.
  - If iPREADY=1 and iPSLVERR=0: oHRDATA<=iPRDATA, next OKAY_RSP.
  - If iPREADY=1 and iPSLVERR=1: oHRDATA<=iPRDATA, next ERR1.
  - If iPREADY=0 and counter==TIMEOUT-1: next ERR1 (abort).
  - Otherwise stay in ACCESS.
  - iPRDATA is captured on every completed ACCESS, reads and writes alike.
  - Exiting ACCESS drops oPSEL/oPENABLE to 0 in the next cycle.
- OKAY_RSP: oHREADY=1 for exactly one cycle, oHRESP=00. Next: IDLE.
- ERR1: oHREADY=0, oHRESP=01. Next: ERR2.
- ERR2: oHREADY=1, oHRESP=01. Next: IDLE.
  - This gives the AHB two-cycle ERROR response.
  - oHRDATA is unchanged on decode miss and on timeout.
- Latency with zero APB wait states:
  - Request sampled at cycle t; SETUP at t+1; ACCESS at t+2; oHREADY=1 at t+3.
  - Each wait state adds one cycle.
  - Back-to-back transfers: the master advances on HREADY. The next request is sampled in the IDLE cycle following OKAY_RSP/ERR2, so 4 cycles per transfer minimum.
- Request inputs are ignored outside IDLE. The latched oPADDR/oPWRITE/oPWDATA stay stable from SETUP through ACCESS end, as APB requires.
- oHREADY is never high in two consecutive cycles.
- The timeout counter is 16 bits and saturates only via the abort transition.

Test Plan:
- Write zero-wait: HADDR=0x8, HWRITE=1, HWDATA=0xF0, PREADY=1 -> PSEL rises t+1, PENABLE t+2, PADDR=0x8, PWDATA=0xF0; HREADY=1 and HRESP=00 at t+3 only.
- Read with 3 wait states: HADDR=0x0, HWRITE=0, PREADY low 3 ACCESS cycles, PRDATA=0x0000_000E -> HREADY at t+6, HRDATA=0xE.
- Decode miss: HADDR=0x0000_2000 -> no PSEL; ERR1 (HREADY=0, HRESP=01), then ERR2 (HREADY=1, HRESP=01); HRDATA unchanged.
- PSLVERR: write with PREADY=1 and PSLVERR=1 -> two-cycle ERROR; PSEL low after ACCESS.
- Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then two-cycle ERROR; next transfer completes normally.
- Async reset asserted during ACCESS -> PSEL/PENABLE/HREADY go 0 without a clock edge. After release, a continuous NONSEQ stream gives HREADY pulses exactly every 4 cycles.

Source files
------------

// File: rtl/ahb2apb_bridge_if.sv
// ============================================================================
// ahb2apb_bridge_if : AHB slave-side and APB master-side signals of the bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ahb2apb_bridge_if;
    // AHB side
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    // APB side
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    // Bridge view
    modport slave (
        input  htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
        output hready, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
    );

    // Environment view: upstream AHB master plus downstream APB slave
    modport master (
        output htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
        input  hready, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
    );
endinterface

`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
// ============================================================================
// ahb2apb_bridge : single-slave AHB-to-APB bridge with decode and ACCESS timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb2apb_bridge #(
    parameter logic [31:0] APB_BASE = 32'h0000_0000,
    parameter logic [31:0] APB_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ahb2apb_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_ACCESS   = 3'd2,
        S_OKAY_RSP = 3'd3,
        S_ERR1     = 3'd4,
        S_ERR2     = 3'd5
    } state_t;

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);
    localparam logic [1:0]  c_resp_okay    = 2'b00;
    localparam logic [1:0]  c_resp_error   = 2'b01;

    state_t      r_state;
    logic [15:0] r_count;

    logic w_req;
    logic w_hit;
    logic w_unused;

    assign w_req    = bus.htrans[1];
    assign w_hit    = (bus.haddr & APB_MASK) == APB_BASE;
    // NONSEQ and SEQ are treated alike, so htrans[0] carries no information
    assign w_unused = bus.htrans[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            bus.hready  <= 1'b0;
            bus.hresp   <= c_resp_okay;
            bus.hrdata  <= 32'd0;
            bus.paddr   <= 32'd0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.pwdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    bus.hready <= 1'b0;
                    bus.hresp  <= c_resp_okay;
                    if (w_req && w_hit) begin
                        bus.paddr  <= bus.haddr;
                        bus.pwrite <= bus.hwrite;
                        bus.pwdata <= bus.hwdata;
                        bus.psel   <= 1'b1;
                        r_state    <= S_SETUP;
                    end else if (w_req) begin
                        bus.hresp <= c_resp_error;
                        r_state   <= S_ERR1;
                    end
                end
                S_SETUP: begin
                    bus.penable <= 1'b1;
                    r_count     <= 16'd0;
                    r_state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.pready) begin
                        bus.hrdata  <= bus.prdata;
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        if (bus.pslverr) begin
                            bus.hresp <= c_resp_error;
                            r_state   <= S_ERR1;
                        end else begin
                            bus.hready <= 1'b1;
                            r_state    <= S_OKAY_RSP;
                        end
                    end else if (r_count == c_timeout_last) begin
                        // Slave never answered: abort without touching hrdata
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        bus.hresp   <= c_resp_error;
                        r_state     <= S_ERR1;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_OKAY_RSP: begin
                    bus.hready <= 1'b0;
                    bus.hresp  <= c_resp_okay;
                    r_state    <= S_IDLE;
                end
                S_ERR1: begin
                    bus.hready <= 1'b1;
                    bus.hresp  <= c_resp_error;
                    r_state    <= S_ERR2;
                end
                S_ERR2: begin
                    bus.hready <= 1'b0;
                    bus.hresp  <= c_resp_okay;
                    r_state    <= S_IDLE;
                end
                default: begin
                    bus.hready  <= 1'b0;
                    bus.hresp   <= c_resp_okay;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
// ============================================================================
// tb_ahb2apb_bridge : scoreboard bench for the AHB-to-APB bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb2apb_bridge;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ahb2apb_bridge_if bus();

    ahb2apb_bridge #(
        .APB_BASE (32'h0000_0000),
        .APB_MASK (32'hFFFF_F000),
        .TIMEOUT  (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  hresp;
        logic [31:0] hrdata;
    } exp_t;

    typedef struct {
        int          psel_cyc;
        int          pen_cyc;
        int          ready_cyc;
        int          acc_cycles;
        logic [1:0]  hresp;
        logic [1:0]  hresp_pre;
        logic        hready_pre;
        logic        psel_pre;
        logic        psel_rdy;
        logic [31:0] hrdata;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        stable;
    } obs_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic drive_idle();
        bus.htrans  = 2'b00;
        bus.hwrite  = 1'b0;
        bus.haddr   = 32'd0;
        bus.hwdata  = 32'd0;
        bus.prdata  = 32'd0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
    endtask

    // AHB master + APB slave model; records what the DUT did, cycle 0 = request cycle
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic slverr, input logic [31:0] rdata,
                            output obs_t o);
        int k = 0;
        logic ph, ps;
        logic [1:0] presp;
        o.psel_cyc = -1; o.pen_cyc = -1; o.ready_cyc = -1; o.acc_cycles = 0;
        o.hresp = 2'b11; o.hresp_pre = 2'b11; o.hready_pre = 1'bx; o.psel_pre = 1'bx;
        o.psel_rdy = 1'bx; o.hrdata = 'x; o.paddr = 'x; o.pwdata = 'x; o.pwrite = 1'bx;
        o.stable = 1'b1;
        @(posedge clk); #1;
        bus.htrans = 2'b10; bus.hwrite = wr; bus.haddr = addr; bus.hwdata = wdata;
        bus.prdata = rdata; bus.pready = 1'b0; bus.pslverr = 1'b0;
        ph = bus.hready; presp = bus.hresp; ps = bus.psel;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.psel && o.psel_cyc < 0) begin
                o.psel_cyc = cyc; o.paddr = bus.paddr; o.pwdata = bus.pwdata; o.pwrite = bus.pwrite;
            end else if (bus.psel && (bus.paddr !== o.paddr || bus.pwdata !== o.pwdata ||
                                      bus.pwrite !== o.pwrite)) begin
                o.stable = 1'b0;
            end
            if (bus.penable && o.pen_cyc < 0) o.pen_cyc = cyc;
            if (bus.hready) begin
                o.ready_cyc = cyc; o.hresp = bus.hresp; o.hrdata = bus.hrdata;
                o.hresp_pre = presp; o.hready_pre = ph; o.psel_pre = ps; o.psel_rdy = bus.psel;
                break;
            end
            if (bus.penable) begin
                o.acc_cycles++;
                bus.pready  = (k >= waits);
                bus.pslverr = slverr && (k >= waits);
                k++;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
            end
            ph = bus.hready; presp = bus.hresp; ps = bus.psel;
        end
        bus.htrans = 2'b00; bus.pready = 1'b0; bus.pslverr = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.hready, bus.hresp, bus.hrdata} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_ahb: got hready=%b hresp=%b hrdata=%h want 0/00/0",
                     bus.hready, bus.hresp, bus.hrdata);
        end
        n_vec++;
        if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_apb_ctl: got psel/penable/pwrite=%b%b%b want 000",
                     bus.psel, bus.penable, bus.pwrite);
        end
        n_vec++;
        if ({bus.paddr, bus.pwdata} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_apb_data: got paddr=%h pwdata=%h want 0/0", bus.paddr, bus.pwdata);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        exp_t e;
        sb.push_back(exp_t'{2'b00, 32'h0000_1234});
        run_xfer(1'b1, 32'h8, 32'hF0, 0, 1'b0, 32'h0000_1234, o);
        n_vec++;
        if (o.psel_cyc !== 1 || o.pen_cyc !== 2 || o.ready_cyc !== 3) begin
            n_err++;
            $display("FAIL wr_timing: got psel@%0d penable@%0d hready@%0d want 1/2/3",
                     o.psel_cyc, o.pen_cyc, o.ready_cyc);
        end
        n_vec++;
        if (o.paddr !== 32'h8 || o.pwdata !== 32'hF0 || o.pwrite !== 1'b1 || !o.stable) begin
            n_err++;
            $display("FAIL wr_apb: got paddr=%h pwdata=%h pwrite=%b stable=%b want 8/f0/1/1",
                     o.paddr, o.pwdata, o.pwrite, o.stable);
        end
        e = sb.pop_front();
        n_vec++;
        if (o.hresp !== e.hresp || o.hrdata !== e.hrdata || o.psel_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_resp: got hresp=%b hrdata=%h psel=%b want %b/%h/0",
                     o.hresp, o.hrdata, o.psel_rdy, e.hresp, e.hrdata);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.hready !== 1'b0 || bus.hresp !== 2'b00) begin
            n_err++;
            $display("FAIL wr_hready_single: got hready=%b hresp=%b at t+4 want 0/00",
                     bus.hready, bus.hresp);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        exp_t e;
        sb.push_back(exp_t'{2'b00, 32'h0000_000E});
        run_xfer(1'b0, 32'h0, 32'h55, 3, 1'b0, 32'h0000_000E, o);
        n_vec++;
        if (o.ready_cyc !== 6 || o.acc_cycles !== 4 || o.pen_cyc !== 2) begin
            n_err++;
            $display("FAIL rd_timing: got hready@%0d access=%0d penable@%0d want 6/4/2",
                     o.ready_cyc, o.acc_cycles, o.pen_cyc);
        end
        n_vec++;
        if (o.paddr !== 32'h0 || o.pwrite !== 1'b0 || !o.stable) begin
            n_err++;
            $display("FAIL rd_apb: got paddr=%h pwrite=%b stable=%b want 0/0/1",
                     o.paddr, o.pwrite, o.stable);
        end
        e = sb.pop_front();
        n_vec++;
        if (o.hresp !== e.hresp || o.hrdata !== e.hrdata) begin
            n_err++;
            $display("FAIL rd_resp: got hresp=%b hrdata=%h want %b/%h", o.hresp, o.hrdata, e.hresp, e.hrdata);
        end
    endtask

    task automatic test_decode_miss();
        obs_t o;
        exp_t e;
        sb.push_back(exp_t'{2'b01, 32'h0000_000E});
        run_xfer(1'b0, 32'h0000_2000, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, o);
        n_vec++;
        if (o.psel_cyc !== -1 || o.ready_cyc !== 2) begin
            n_err++;
            $display("FAIL miss_timing: got psel@%0d hready@%0d want none(-1)/2", o.psel_cyc, o.ready_cyc);
        end
        n_vec++;
        if (o.hready_pre !== 1'b0 || o.hresp_pre !== 2'b01) begin
            n_err++;
            $display("FAIL miss_err1: got hready=%b hresp=%b want 0/01", o.hready_pre, o.hresp_pre);
        end
        e = sb.pop_front();
        n_vec++;
        if (o.hresp !== e.hresp || o.hrdata !== e.hrdata) begin
            n_err++;
            $display("FAIL miss_resp: got hresp=%b hrdata=%h want %b/%h", o.hresp, o.hrdata, e.hresp, e.hrdata);
        end
    endtask

    task automatic test_pslverr();
        obs_t o;
        exp_t e;
        sb.push_back(exp_t'{2'b01, 32'hBAD0_0001});
        run_xfer(1'b1, 32'h10, 32'h77, 0, 1'b1, 32'hBAD0_0001, o);
        n_vec++;
        if (o.ready_cyc !== 4 || o.acc_cycles !== 1) begin
            n_err++;
            $display("FAIL slverr_timing: got hready@%0d access=%0d want 4/1", o.ready_cyc, o.acc_cycles);
        end
        n_vec++;
        if (o.psel_pre !== 1'b0 || o.hready_pre !== 1'b0 || o.hresp_pre !== 2'b01) begin
            n_err++;
            $display("FAIL slverr_err1: got psel=%b hready=%b hresp=%b want 0/0/01",
                     o.psel_pre, o.hready_pre, o.hresp_pre);
        end
        e = sb.pop_front();
        n_vec++;
        if (o.hresp !== e.hresp || o.hrdata !== e.hrdata) begin
            n_err++;
            $display("FAIL slverr_resp: got hresp=%b hrdata=%h want %b/%h", o.hresp, o.hrdata, e.hresp, e.hrdata);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back(exp_t'{2'b01, 32'hBAD0_0001});
        run_xfer(1'b0, 32'h4, 32'h0, 1000, 1'b0, 32'h1111_1111, o);
        n_vec++;
        if (o.acc_cycles !== TO || o.ready_cyc !== TO + 3) begin
            n_err++;
            $display("FAIL to_timing: got access=%0d hready@%0d want %0d/%0d",
                     o.acc_cycles, o.ready_cyc, TO, TO + 3);
        end
        n_vec++;
        if (o.psel_pre !== 1'b0 || o.hready_pre !== 1'b0 || o.hresp_pre !== 2'b01) begin
            n_err++;
            $display("FAIL to_err1: got psel=%b hready=%b hresp=%b want 0/0/01",
                     o.psel_pre, o.hready_pre, o.hresp_pre);
        end
        e = sb.pop_front();
        n_vec++;
        if (o.hresp !== e.hresp || o.hrdata !== e.hrdata) begin
            n_err++;
            $display("FAIL to_resp: got hresp=%b hrdata=%h want %b/%h", o.hresp, o.hrdata, e.hresp, e.hrdata);
        end
        sb.push_back(exp_t'{2'b00, 32'h2222_2222});
        run_xfer(1'b0, 32'hC, 32'h0, 1, 1'b0, 32'h2222_2222, o);
        e = sb.pop_front();
        n_vec++;
        if (o.ready_cyc !== 4 || o.hresp !== e.hresp || o.hrdata !== e.hrdata) begin
            n_err++;
            $display("FAIL to_recover: got hready@%0d hresp=%b hrdata=%h want 4/%b/%h",
                     o.ready_cyc, o.hresp, o.hrdata, e.hresp, e.hrdata);
        end
    endtask

    task automatic test_async_reset_stream();
        bit seen = 1'b0;
        int pulses[$];
        exp_t e;
        @(posedge clk); #1;
        bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'h4; bus.hwdata = 32'h99; bus.pready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.penable) begin seen = 1'b1; break; end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_access_reached: got penable never high want high within 10 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.psel, bus.penable, bus.hready, bus.hresp} !== 5'd0) begin
            n_err++;
            $display("FAIL rst_async: got psel/penable/hready/hresp=%b%b%b%b want 00000",
                     bus.psel, bus.penable, bus.hready, bus.hresp);
        end
        bus.htrans = 2'b00;
        @(negedge clk) rst_n = 1'b1;
        bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = 32'h8; bus.prdata = 32'hA5; bus.pready = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(exp_t'{2'b00, 32'h0000_00A5});
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (bus.hready) begin
                pulses.push_back(cyc);
                e = sb.pop_front();
                n_vec++;
                if (bus.hresp !== e.hresp || bus.hrdata !== e.hrdata) begin
                    n_err++;
                    $display("FAIL stream_resp@%0d: got hresp=%b hrdata=%h want %b/%h",
                             cyc, bus.hresp, bus.hrdata, e.hresp, e.hrdata);
                end
            end
        end
        drive_idle();
        sb.delete();
        n_vec++;
        if (pulses.size() != 7 || pulses[0] != 3) begin
            n_err++;
            $display("FAIL stream_count: got %0d pulses first@%0d want 7 first@3",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_vec++;
            if (pulses[i] - pulses[i-1] != 4) begin
                n_err++;
                $display("FAIL stream_period: got %0d cycles between pulses want 4", pulses[i] - pulses[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_decode_miss();
        test_pslverr();
        test_timeout();
        test_async_reset_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
